tdp_ram_be_clr: RTL and testbench

TDP_RAM_BE_CLR -- requirements
Module: tdp_ram_be_clr

---
 rtl/tdp_ram_be_clr_if.sv | 21 ++
 rtl/tdp_ram_be_clr.sv | 80 ++++++++
 tb/tb_tdp_ram_be_clr.sv | 119 +++++++++++
 3 files changed

// File: rtl/tdp_ram_be_clr_if.sv
// tdp_ram_be_clr_if: port bundle for the dual-port byte-enable RAM with clear sequencer.
interface tdp_ram_be_clr_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  logic en1, en2;
  logic [NB-1:0] we1, we2;
  logic [ADDR_WIDTH-1:0] addr1, addr2;
  logic [DATA_WIDTH-1:0] din1, din2, dout1, dout2;
  logic init_busy, collision;
  modport master (
    output en1, en2, we1, we2, addr1, addr2, din1, din2,
    input dout1, dout2, init_busy, collision
  );
  modport slave (
    input en1, en2, we1, we2, addr1, addr2, din1, din2,
    output dout1, dout2, init_busy, collision
  );
endinterface

// File: rtl/tdp_ram_be_clr.sv
// tdp_ram_be_clr: true dual-port byte-enable RAM that clears itself after reset.
// Define TDP_RAM_BE_CLR_COLLISION_EN to get a registered same-address write collision flag.
module tdp_ram_be_clr #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter string WRITE_MODE_1 = "READ_FIRST",
  parameter string WRITE_MODE_2 = "READ_FIRST",
  parameter string OUTPUT_REG_1 = "FALSE",
  parameter string OUTPUT_REG_2 = "FALSE",
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input logic clk,
  input logic rst,
  tdp_ram_be_clr_if.slave bus
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  typedef enum logic {CLEAR, READY} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_q, clr_d;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r1_q, r1_d, r2_q, r2_d, o1_q, o1_d, o2_q, o2_d;
  logic v1_q, v1_d, v2_q, v2_d, rdy, wr1, wr2;
  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old, din,
                                                  input logic [NB-1:0] we);
    merge = old;
    for (int i = 0; i < NB; i++)
      if (we[i]) merge[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
  endfunction
  always_comb begin
    rdy = state_q == READY;
    wr1 = bus.en1 && |bus.we1;
    wr2 = bus.en2 && |bus.we2;
    state_d = (state_q == CLEAR && &clr_q) ? READY : state_q;
    clr_d = (state_q == CLEAR) ? clr_q + 1'b1 : clr_q;
    r1_d = !(rdy && bus.en1) ? r1_q :
           (wr1 && WRITE_MODE_1 == "NO_CHANGE") ? r1_q :
           (wr1 && WRITE_MODE_1 == "WRITE_FIRST") ? merge(mem[bus.addr1], bus.din1, bus.we1) :
           mem[bus.addr1];
    r2_d = !(rdy && bus.en2) ? r2_q :
           (wr2 && WRITE_MODE_2 == "NO_CHANGE") ? r2_q :
           (wr2 && WRITE_MODE_2 == "WRITE_FIRST") ? merge(mem[bus.addr2], bus.din2, bus.we2) :
           mem[bus.addr2];
    v1_d = rdy && bus.en1;
    v2_d = rdy && bus.en2;
    o1_d = v1_q ? r1_q : o1_q;
    o2_d = v2_q ? r2_q : o2_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= CLEAR;
      clr_q <= '0;
      {r1_q, r2_q, o1_q, o2_q, v1_q, v2_q} <= '0;
    end else begin
      state_q <= state_d;
      clr_q <= clr_d;
      {r1_q, r2_q, o1_q, o2_q, v1_q, v2_q} <= {r1_d, r2_d, o1_d, o2_d, v1_d, v2_d};
    end
  // Port 1 lane writes come last so they win overlapping lanes on a shared address.
  always_ff @(posedge clk)
    if (!rdy) mem[clr_q] <= CLEAR_VALUE;
    else
      for (int i = 0; i < NB; i++) begin
        if (bus.en2 && bus.we2[i]) mem[bus.addr2][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.din2[i*BYTE_WIDTH +: BYTE_WIDTH];
        if (bus.en1 && bus.we1[i]) mem[bus.addr1][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.din1[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
  assign bus.dout1 = (OUTPUT_REG_1 == "TRUE") ? o1_q : r1_q;
  assign bus.dout2 = (OUTPUT_REG_2 == "TRUE") ? o2_q : r2_q;
  assign bus.init_busy = !rdy;
`ifdef TDP_RAM_BE_CLR_COLLISION_EN
  logic col_q, col_d;
  always_comb col_d = rdy && bus.en1 && bus.en2 && bus.addr1 == bus.addr2 && (|bus.we1 || |bus.we2);
  always_ff @(posedge clk or posedge rst)
    if (rst) col_q <= 1'b0;
    else col_q <= col_d;
  assign bus.collision = col_q;
`else
  assign bus.collision = 1'b0;
`endif
endmodule

// File: tb/tb_tdp_ram_be_clr.sv
// tb_tdp_ram_be_clr: directed vector bench for tdp_ram_be_clr (default build and a registered-output variant).
module tb_tdp_ram_be_clr;
`ifdef TDP_RAM_BE_CLR_COLLISION_EN
  localparam bit COL = 1'b1;
`else
  localparam bit COL = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  int n_vec = 0, n_bad = 0, cnt;
  always #5 clk = ~clk;
  tdp_ram_be_clr_if #(32, 8, 9) ia ();
  tdp_ram_be_clr_if #(32, 8, 9) ib ();
  tdp_ram_be_clr dut_a (.clk(clk), .rst(rst), .bus(ia));
  tdp_ram_be_clr #(.WRITE_MODE_1("WRITE_FIRST"), .OUTPUT_REG_1("TRUE"),
                   .WRITE_MODE_2("READ_FIRST"), .OUTPUT_REG_2("TRUE")) dut_b (.clk(clk), .rst(rst), .bus(ib));
  typedef struct {
    logic en1; logic [3:0] we1; logic [8:0] a1; logic [31:0] d1;
    logic en2; logic [3:0] we2; logic [8:0] a2; logic [31:0] d2;
    logic [31:0] e1, e2; logic ec;
  } vec_t;
  vec_t tv [9];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle();
    {ia.en1, ia.en2, ia.we1, ia.we2, ia.addr1, ia.addr2, ia.din1, ia.din2} = '0;
    {ib.en1, ib.en2, ib.we1, ib.we2, ib.addr1, ib.addr2, ib.din1, ib.din2} = '0;
  endtask
  initial begin
    tv[0] = '{1, 4'hF, 9'd5, 32'hAABBCCDD, 1, 4'h0, 9'd5, 32'h0, 32'h0, 32'h0, 1};
    tv[1] = '{1, 4'h2, 9'd5, 32'h00001100, 1, 4'h0, 9'd5, 32'h0, 32'hAABBCCDD, 32'hAABBCCDD, 1};
    tv[2] = '{0, 4'h0, 9'd0, 32'h0, 1, 4'h0, 9'd5, 32'h0, 32'hAABBCCDD, 32'hAABB11DD, 0};
    tv[3] = '{1, 4'h3, 9'd7, 32'h11111111, 1, 4'h6, 9'd7, 32'h22222222, 32'h0, 32'h0, 1};
    tv[4] = '{1, 4'h0, 9'd7, 32'h0, 1, 4'h0, 9'd0, 32'h0, 32'h00221111, 32'h0, 0};
    tv[5] = '{1, 4'h0, 9'd255, 32'h0, 1, 4'h0, 9'd511, 32'h0, 32'h0, 32'h0, 0};
    tv[6] = '{1, 4'h0, 9'd9, 32'h0, 1, 4'h8, 9'd9, 32'h99000000, 32'h0, 32'h0, 1};
    tv[7] = '{1, 4'h0, 9'd9, 32'hFFFFFFFF, 0, 4'h0, 9'd0, 32'h0, 32'h99000000, 32'h0, 0};
    tv[8] = '{0, 4'h0, 9'd0, 32'h0, 1, 4'h0, 9'd9, 32'h0, 32'h99000000, 32'h99000000, 0};
    idle();
    repeat (3) step();
    chk("rst_busy", {31'b0, ia.init_busy}, 1);
    chk("rst_dout1", ia.dout1, 0);
    chk("rst_dout2", ia.dout2, 0);
    chk("rst_col", {31'b0, ia.collision}, 0);
    rst = 1'b0;
    cnt = 0;
    while (ia.init_busy && cnt < 1000) begin
      step();
      cnt++;
    end
    chk("clear_len", cnt, 512);
    chk("clear_len_b", {31'b0, ib.init_busy}, 0);
    for (int i = 0; i < 9; i++) begin
      {ia.en1, ia.we1, ia.addr1, ia.din1} = {tv[i].en1, tv[i].we1, tv[i].a1, tv[i].d1};
      {ia.en2, ia.we2, ia.addr2, ia.din2} = {tv[i].en2, tv[i].we2, tv[i].a2, tv[i].d2};
      step();
      chk($sformatf("v%0d_dout1", i), ia.dout1, tv[i].e1);
      chk($sformatf("v%0d_dout2", i), ia.dout2, tv[i].e2);
      chk($sformatf("v%0d_col", i), {31'b0, ia.collision}, {31'b0, COL & tv[i].ec});
    end
    idle();
    {ib.en1, ib.we1, ib.addr1, ib.din1} = {1'b1, 4'hF, 9'd3, 32'h12345678};
    {ib.en2, ib.addr2} = {1'b1, 9'd3};
    step();
    idle();
    chk("wf_reg_early", ib.dout1, 0);
    step();
    chk("wf_reg_dout1", ib.dout1, 32'h12345678);
    chk("rf_reg_dout2", ib.dout2, 0);
    {ib.en2, ib.we2, ib.addr2, ib.din2} = {1'b1, 4'hF, 9'd3, 32'hCAFEF00D};
    step();
    idle();
    step();
    chk("rf_reg_old", ib.dout2, 32'h12345678);
    rst = 1'b1;
    #1;
    chk("async_rst_dout1", ia.dout1, 0);
    chk("async_rst_busy", {31'b0, ia.init_busy}, 1);
    chk("async_rst_b_dout1", ib.dout1, 0);
    step();
    rst = 1'b0;
    repeat (200) step();
    chk("mid_busy", {31'b0, ia.init_busy}, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    cnt = 0;
    while (ia.init_busy && cnt < 1000) begin
      if (cnt == 300) begin
        {ia.en1, ia.we1, ia.addr1, ia.din1} = {1'b1, 4'hF, 9'd10, 32'hFFFFFFFF};
        {ia.en2, ia.we2, ia.addr2, ia.din2} = {1'b1, 4'hF, 9'd10, 32'h77777777};
      end
      if (cnt == 301) begin
        chk("clr_dout1", ia.dout1, 0);
        chk("clr_dout2", ia.dout2, 0);
        chk("clr_col", {31'b0, ia.collision}, 0);
        idle();
      end
      step();
      cnt++;
    end
    chk("reclear_len", cnt, 512);
    {ia.en1, ia.addr1, ia.en2, ia.addr2} = {1'b1, 9'd10, 1'b1, 9'd5};
    step();
    idle();
    chk("clr_write_dropped", ia.dout1, 0);
    chk("reclear_addr5", ia.dout2, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
